// File: rtl/fifo_rr_drain_arbiter.sv
// fifo_rr_drain_arbiter
//   Round-robin drain of NUM_SRC first-word-fall-through fifos into a single
//   valid/ready consumer port. The fifo head is popped in the same cycle it
//   is granted. The popped word is then held in a one-beat output register,
//   so valid_o rises one cycle after the pop.
//
//   Optional feature (macro FIFO_ARB_BURST_EN):
//     When the macro is defined, the block stays locked on a source for up to
//     MAX_BURST consecutive grants. In the default build, arbitration is
//     strict per-beat round-robin and MAX_BURST has no effect.
//
// Ports
//   clk_i         clock, rising edge
//   rst_ni        synchronous active-low reset
//   flush_i       drop the output beat and return the pointer to source 0
//   fifo_empty_i  per-source empty flag (head invalid when 1)
//   fifo_data_i   per-source head data, slice k = [k*DATA_W +: DATA_W]
//   fifo_read_o   per-source pop strobe, one-hot or zero
//   valid_o       output beat valid
//   ready_i       consumer accepts the beat when valid_o && ready_i
//   data_o        output beat data
//   src_o         index of the source that produced data_o
//   busy_o        valid_o high or any fifo non-empty
module fifo_rr_drain_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 16,
  parameter int SRC_W     = $clog2(NUM_SRC),
  parameter int MAX_BURST = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic [NUM_SRC-1:0]        fifo_empty_i,
  input  logic [NUM_SRC*DATA_W-1:0] fifo_data_i,
  output logic [NUM_SRC-1:0]        fifo_read_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [DATA_W-1:0]         data_o,
  output logic [SRC_W-1:0]          src_o,
  output logic                      busy_o
);

  if (NUM_SRC < 2 || NUM_SRC > 16 || MAX_BURST < 1) begin : g_param_chk
    $error("fifo_rr_drain_arbiter: NUM_SRC must be 2..16 and MAX_BURST >= 1");
  end

  localparam logic [SRC_W:0]   NSRC = (SRC_W+1)'(NUM_SRC);
  localparam logic [SRC_W-1:0] LAST = SRC_W'(NUM_SRC-1);

  // Next index after s, wrapping from NUM_SRC-1 to 0.
  // This also works when NUM_SRC is not a power of two.
  function automatic logic [SRC_W-1:0] f_inc(input logic [SRC_W-1:0] s);
    return (s == LAST) ? '0 : s + SRC_W'(1);
  endfunction

  logic                            r_valid;
  logic [DATA_W-1:0]               r_data;
  logic [SRC_W-1:0]                r_src;
  logic [SRC_W-1:0]                r_ptr;

  logic [NUM_SRC-1:0][DATA_W-1:0]  w_data;
  logic                            w_free;
  logic                            w_found;
  logic                            w_grant;
  logic [SRC_W-1:0]                w_win;
  logic [SRC_W-1:0]                w_start;
  logic [SRC_W:0]                  w_sum;
  logic [SRC_W-1:0]                w_ptr_nxt;

  assign w_data = fifo_data_i;
  assign w_free = !r_valid || ready_i;

  // Find the first non-empty source, scanning upward from w_start with wrap-around.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_sum = {1'b0, w_start} + (SRC_W+1)'(i);
      if (w_sum >= NSRC) w_sum = w_sum - NSRC;
      if (!w_found && !fifo_empty_i[w_sum[SRC_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[SRC_W-1:0];
      end
    end
  end

  // Reset and flush both block the pop, so a fifo never loses a word
  // that the output register does not capture.
  assign w_grant = rst_ni && w_free && !flush_i && w_found;

  always_comb begin
    fifo_read_o = '0;
    for (int k = 0; k < NUM_SRC; k++)
      fifo_read_o[k] = w_grant && (w_win == SRC_W'(k));
  end

`ifdef FIFO_ARB_BURST_EN
  localparam int CNT_W = $clog2(MAX_BURST+1);
  localparam logic [CNT_W-1:0] MAXB = CNT_W'(MAX_BURST);

  typedef enum logic {S_RR, S_LOCK} state_t;

  state_t           r_state, w_state_nxt;
  logic [SRC_W-1:0] r_lock_src, w_lock_src_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;

  // While locked, the scan starts at the locked source. The locked source
  // therefore wins while it is non-empty. When it empties, the scan moves on
  // to the source after it, which is the same as releasing the lock.
  assign w_start = (r_state == S_LOCK) ? r_lock_src : r_ptr;

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_src_nxt = r_lock_src;
    w_cnt_nxt      = r_cnt;
    w_ptr_nxt      = r_ptr;
    w_cnt_inc      = ((r_state == S_LOCK && w_win == r_lock_src) ? r_cnt : '0)
                     + CNT_W'(1);
    // The locked source ran dry, so release the lock behind it.
    if (r_state == S_LOCK && fifo_empty_i[r_lock_src]) begin
      w_state_nxt = S_RR;
      w_ptr_nxt   = f_inc(r_lock_src);
      w_cnt_nxt   = '0;
    end
    if (w_grant) begin
      if (w_cnt_inc >= MAXB) begin
        w_state_nxt = S_RR;
        w_ptr_nxt   = f_inc(w_win);
        w_cnt_nxt   = '0;
      end else begin
        w_state_nxt    = S_LOCK;
        w_lock_src_nxt = w_win;
        w_cnt_nxt      = w_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      r_state    <= S_RR;
      r_lock_src <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_src <= w_lock_src_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end
`else
  assign w_start   = r_ptr;
  assign w_ptr_nxt = w_grant ? f_inc(w_win) : r_ptr;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
      r_ptr   <= '0;
    end else if (flush_i) begin
      // A beat accepted in the same cycle is still dropped. The data and
      // source registers keep their old values, and only valid clears.
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else begin
      if (w_grant) begin
        r_valid <= 1'b1;
        r_data  <= w_data[w_win];
        r_src   <= w_win;
      end else if (ready_i) begin
        r_valid <= 1'b0;
      end
      r_ptr <= w_ptr_nxt;
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign src_o   = r_src;
  assign busy_o  = r_valid || !(&fifo_empty_i);

endmodule

// File: tb/tb_fifo_rr_drain_arbiter.sv
// Directed bench for fifo_rr_drain_arbiter with four fifo models and
// hand-computed expected beats.
module tb_fifo_rr_drain_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni, flush_i, ready_i;
  logic [3:0]  fifo_empty;
  logic [63:0] fifo_data;
  logic [3:0]  fifo_read;
  logic        valid;
  logic [15:0] data;
  logic [1:0]  src;
  logic        busy;

  logic [15:0] mem [4][32];
  int          cnt [4];
  int          hd  [4];
  int          nvec = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  fifo_rr_drain_arbiter dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data),
    .fifo_read_o(fifo_read), .valid_o(valid), .ready_i(ready_i),
    .data_o(data), .src_o(src), .busy_o(busy)
  );

  // First-word-fall-through fifo models. The head advances on a pop.
  always_comb begin
    fifo_empty = '0;
    fifo_data  = '0;
    for (int k = 0; k < 4; k++) begin
      fifo_empty[k]        = (hd[k] >= cnt[k]);
      fifo_data[k*16 +: 16] = mem[k][hd[k] & 31];
    end
  end

  always @(posedge clk)
    for (int k = 0; k < 4; k++)
      if (fifo_read[k]) hd[k] <= hd[k] + 1;

  task automatic push(input int k, input logic [15:0] w);
    mem[k][cnt[k]] = w;
    cnt[k]++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ek, ew;
`ifdef FIFO_ARB_BURST_EN
    int bsrc [12] = '{0,0,0,0,1,1,1,1,0,0,1,1};
    int bwrd [12] = '{0,1,2,3,0,1,2,3,4,5,4,5};
`endif
    rst_ni = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_data",  data, 0);
    check("rst_src",   src, 0);
    check("rst_read",  fifo_read, 0);
    rst_ni = 1'b1;

    // The block stays idle while every fifo is empty.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_valid", valid, 0);
      check("idle_read",  fifo_read, 0);
      check("idle_busy",  busy, 0);
    end

    // Four fifos with two words each, drained back-to-back.
    for (int k = 0; k < 4; k++)
      for (int w = 0; w < 2; w++)
        push(k, 16'hA000 | 16'(k << 4) | 16'(w));
    ready_i = 1'b1;
    #1;
    check("rr_first_pop", fifo_read, 4'b0001);
    check("rr_no_latency", valid, 0);
    check("rr_busy", busy, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
`ifdef FIFO_ARB_BURST_EN
      ek = i / 2; ew = i % 2;
`else
      ek = i % 4; ew = i / 4;
`endif
      check("rr_valid", valid, 1);
      check("rr_src",   src, ek);
      check("rr_data",  data, 32'hA000 | (ek << 4) | ew);
    end
    @(negedge clk);
    check("rr_drain_valid", valid, 0);
    check("rr_hold_data",   data, 16'hA031);
    check("rr_hold_src",    src, 3);
    check("rr_drain_busy",  busy, 0);

    // A single non-empty source is granted on every free cycle.
    push(2, 16'hB200); push(2, 16'hB201); push(2, 16'hB202);
    #1;
    check("one_pop", fifo_read, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("one_valid", valid, 1);
      check("one_src",   src, 2);
      check("one_data",  data, 16'hB200 + 16'(i));
    end
    @(negedge clk);
    check("one_drain", valid, 0);

    // While the consumer stalls, the beat holds and nothing is popped.
    ready_i = 1'b0;
    push(1, 16'h1234); push(1, 16'h5678);
    #1;
    check("stall_first_pop", fifo_read, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", valid, 1);
      check("stall_data",  data, 16'h1234);
      check("stall_read",  fifo_read, 0);
      check("stall_busy",  busy, 1);
    end
    ready_i = 1'b1;
    #1;
    check("stall_release_pop", fifo_read, 4'b0010);
    @(negedge clk);
    check("stall_next_valid", valid, 1);
    check("stall_next_data",  data, 16'h5678);
    check("stall_next_src",   src, 1);
    @(negedge clk);
    check("stall_drain", valid, 0);

    // Flush drops an accepted beat and sends the pointer back to source 0.
    push(2, 16'hC200); push(2, 16'hC201); push(0, 16'hC000); push(3, 16'hC300);
    #1;
    check("fl_pop2", fifo_read, 4'b0100);
    @(negedge clk);
    check("fl_pre_data", data, 16'hC200);
    check("fl_pre_valid", valid, 1);
    flush_i = 1'b1;
    #1;
    check("fl_no_pop", fifo_read, 0);
    @(negedge clk);
    flush_i = 1'b0;
    check("fl_dropped", valid, 0);
    #1;
    check("fl_scan_from0", fifo_read, 4'b0001);
    @(negedge clk);
    check("fl_b0_data", data, 16'hC000);
    check("fl_b0_src",  src, 0);
    @(negedge clk);
    check("fl_b1_data", data, 16'hC201);
    check("fl_b1_src",  src, 2);
    @(negedge clk);
    check("fl_b2_data", data, 16'hC300);
    check("fl_b2_src",  src, 3);
    @(negedge clk);
    check("fl_drain", valid, 0);

    // Reset mid-stream: the pending beat is lost, and the fifo word stays.
    push(1, 16'hD100); push(1, 16'hD101);
    #1;
    check("mr_pop", fifo_read, 4'b0010);
    @(negedge clk);
    check("mr_pre_data", data, 16'hD100);
    rst_ni = 1'b0;
    #1;
    check("mr_rst_no_pop", fifo_read, 0);
    @(negedge clk);
    check("mr_valid", valid, 0);
    check("mr_data",  data, 0);
    check("mr_src",   src, 0);
    rst_ni = 1'b1;
    #1;
    check("mr_resume_pop", fifo_read, 4'b0010);
    @(negedge clk);
    check("mr_resume_data", data, 16'hD101);
    check("mr_resume_src",  src, 1);
    @(negedge clk);
    check("mr_drain", valid, 0);

`ifdef FIFO_ARB_BURST_EN
    // Burst lock with MAX_BURST=4 and six words in fifos 0 and 1.
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 6; w++)
        push(k, 16'hE000 | 16'(k << 4) | 16'(w));
    #1;
    check("bu_first_pop", fifo_read, 4'b0001);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("bu_valid", valid, 1);
      check("bu_src",   src, bsrc[i]);
      check("bu_data",  data, 32'hE000 | (bsrc[i] << 4) | bwrd[i]);
    end
    @(negedge clk);
    check("bu_drain", valid, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fifo_rr_drain_arbiter.md
Name: fifo_rr_drain_arbiter

Overview:
- Round-robin scheduler that drains NUM_SRC first-word-fall-through fifo instances into one shared valid/ready consumer port.
- Each source is a fifo: its empty_o drives fifo_empty_i[k], its dout_o drives the k-th data slice, and fifo_read_o[k] drives its read_i.
- Sits between per-requester queues and a single downstream engine.
- Output is a registered one-beat stage, giving a one-cycle pop-to-valid latency.

Parameters:
NUM_SRC, 4, number of source fifos (2..16)
DATA_W, 16, data width per source and at the output
SRC_W, $clog2(NUM_SRC), width of the source index
MAX_BURST, 4, max consecutive grants to one source; used only with the optional feature

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  reset, synchronous, active-low
flush_i  input  1  synchronous flush: drop the output beat, reset the pointer
fifo_empty_i  input  NUM_SRC  per-source fifo empty (head invalid when 1)
fifo_data_i  input  NUM_SRC*DATA_W  per-source fifo head data; slice k = bits [k*DATA_W +: DATA_W]
fifo_read_o  output  NUM_SRC  per-source pop strobe, at most one bit high (one-hot or zero)
valid_o  output  1  output beat valid
ready_i  input  1  consumer accepts the beat when valid_o && ready_i
data_o  output  DATA_W  output beat data
src_o  output  SRC_W  index of the source that produced data_o
busy_o  output  1  valid_o high or any fifo_empty_i low

Behaviour:
- Reset (rst_ni=0 at the edge):
  - valid_o=0, data_o=0, src_o=0, rr_ptr=0.
  - fifo_read_o=0 combinationally while rst_ni=0.
- Slot free condition: free = !valid_q || ready_i.
- Grant:
  - When free && !flush_i, the winner is the first k with fifo_empty_i[k]=0, scanning rr_ptr, rr_ptr+1, ... mod NUM_SRC (wrap-around).
  - fifo_read_o[winner]=1 in the same cycle (combinational).
  - No winner -> fifo_read_o=0.
- Load: on the edge after a grant, data_q<=fifo_data_i[winner], src_q<=winner, valid_q<=1, rr_ptr<=(winner+1) mod NUM_SRC. When winner=NUM_SRC-1, the pointer wraps to 0.
- Drain without a refill: if valid_o && ready_i and there is no winner, valid_q<=0. data_o and src_o hold their last values.
- Back-to-back: with ready_i held at 1 and sources non-empty, one beat is issued per cycle (full throughput, no bubble).
- Stall: valid_o && !ready_i -> no pops; data_o and src_o stable; valid_o stays 1.
- Flush:
  - flush_i=1 -> fifo_read_o=0 that cycle.
  - Next edge: valid_q<=0, rr_ptr<=0.
  - Flush takes priority over ready_i; an accepted beat in the same cycle is still dropped.
- Single non-empty source: it is granted every free cycle regardless of rr_ptr.
- Reset mid-stream: the pending beat is lost; fifo contents are untouched by this block.
- busy_o is combinational from valid_q and fifo_empty_i.

Optional Feature:
- Macro: FIFO_ARB_BURST_EN.
- Defined:
  - Adds a burst counter (width $clog2(MAX_BURST+1)) and a LOCK state.
  - After a grant to source k, the block stays locked on k while fifo_empty_i[k]=0 and fewer than MAX_BURST consecutive grants have gone to k. rr_ptr is not advanced during the lock.
  - On the MAX_BURST-th grant, or when k empties, the lock releases: rr_ptr<=k+1 and the counter resets.
  - Flush and reset clear the lock and the counter.
- Undefined: strict per-beat round-robin as described above; the MAX_BURST parameter is ignored.

Test Plan:
- Reset, then all fifos empty -> valid_o=0, fifo_read_o=0, busy_o=0 for 10 cycles.
- Fifos 0..3 each hold 2 words (0xA0k0, 0xA0k1), ready_i=1 -> src_o sequence 0,1,2,3,0,1,2,3 on consecutive cycles, first valid_o one cycle after the first pop.
- Only fifo 2 non-empty with 3 words, ready_i=1 -> src_o=2 for 3 consecutive beats, then valid_o=0.
- valid_o=1 with data_o=0x1234 and ready_i=0 for 5 cycles -> data_o=0x1234 held, fifo_read_o=0 throughout; ready_i=1 -> next beat loads on the following edge.
- flush_i pulsed while valid_o=1 and ready_i=1 -> valid_o=0 next cycle, no pop during the flush cycle, next grant scans from source 0.
- With FIFO_ARB_BURST_EN and MAX_BURST=4, fifos 0 and 1 each holding 6 words -> src_o sequence 0,0,0,0,1,1,1,1,0,0,1,1.
